// File: rtl/fft16_pkg.sv
// Shared sizes and FSM state type for the FFT16 butterfly scheduler.
package fft16_pkg;

    localparam int unsigned POINTS = 16;
    localparam int unsigned STAGES = 4;
    localparam int unsigned ADDR_W = STAGES;
    localparam int unsigned TW_W   = STAGES - 1;
    localparam int unsigned BF_W   = STAGES - 1;
    localparam int unsigned STG_W  = $clog2(STAGES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fft16_addr_gen.sv
// Combinational DIT operand-address and twiddle-index generator for one
// (stage, butterfly) pair of the 16-point in-place FFT.
module fft16_addr_gen
    import fft16_pkg::*;
(
    input  logic [STG_W-1:0]  stage_i,
    input  logic [BF_W-1:0]   bf_i,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic [TW_W-1:0]   tw_idx_o
);

    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] grp;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;

    always_comb begin
        half     = ADDR_W'(1) << stage_i;
        pos      = ADDR_W'(bf_i) & (half - ADDR_W'(1));
        grp      = ADDR_W'(bf_i) >> stage_i;
        // grp * 2 * half, wrapping modulo POINTS
        base     = (grp << stage_i) << 1;
        a        = (base + pos) & ADDR_W'(POINTS - 1);
        addr_a_o = a;
        addr_b_o = (a + half) & ADDR_W'(POINTS - 1);
        tw_idx_o = TW_W'(pos << (STG_W'(TW_W) - stage_i));
    end

endmodule

// File: rtl/fft16_scheduler.sv
// FSM sequencing the shared radix-2 butterfly through 4 stages x 8 butterflies.
// Optional WAIT watchdog enabled by defining FFT16_TIMEOUT_EN.
module fft16_scheduler
    import fft16_pkg::*;
#(
`ifdef FFT16_TIMEOUT_EN
    parameter int unsigned TO_CYCLES = 15
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_bf_done,
    output logic              o_busy,
    output logic              o_bf_start,
    output logic [STAGES-1:0] o_addr_a,
    output logic [STAGES-1:0] o_addr_b,
    output logic [STAGES-2:0] o_tw_idx,
    output logic [1:0]        o_stage,
    output logic [STAGES-2:0] o_bf_idx,
    output logic              o_rd_bank,
    output logic              o_wr_en,
    output logic              o_FFT_cycle_done,
    output logic              o_timeout
);

    state_t            state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [BF_W-1:0]   bf_q, bf_d;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic [TW_W-1:0]   tw_q;
    logic [ADDR_W-1:0] gen_a, gen_b;
    logic [TW_W-1:0]   gen_tw;
    logic              last_bf;
    logic              to_hit;

    assign last_bf = (stage_q == STG_W'(STAGES - 1)) && (bf_q == '1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_bf_done)   state_d = ST_WRITE;
                else if (to_hit) state_d = ST_DONE;
            end
            ST_WRITE: state_d = last_bf ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy           = (state_q != ST_IDLE);
        o_bf_start       = (state_q == ST_ISSUE);
        o_wr_en          = (state_q == ST_WRITE);
        o_FFT_cycle_done = (state_q == ST_DONE);
        o_addr_a         = addr_a_q;
        o_addr_b         = addr_b_q;
        o_tw_idx         = tw_q;
        o_stage          = stage_q;
        o_bf_idx         = bf_q;
        o_rd_bank        = stage_q[0];
    end

    always_comb begin
        stage_d = stage_q;
        bf_d    = bf_q;
        if (state_q == ST_WRITE) begin
            bf_d = bf_q + 1'b1;
            if (bf_q == '1) stage_d = stage_q + 1'b1;
        end else if (state_q == ST_DONE) begin
            stage_d = '0;
            bf_d    = '0;
        end
    end

    fft16_addr_gen u_addr_gen (
        .stage_i  (stage_d),
        .bf_i     (bf_d),
        .addr_a_o (gen_a),
        .addr_b_o (gen_b),
        .tw_idx_o (gen_tw)
    );

    // Addresses are computed from next-state counters and captured on every
    // entry to ISSUE, so they hold steady from ISSUE through WRITE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stage_q  <= '0;
            bf_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            stage_q <= stage_d;
            bf_q    <= bf_d;
            if (state_d == ST_ISSUE) begin
                addr_a_q <= gen_a;
                addr_b_q <= gen_b;
                tw_q     <= gen_tw;
            end
        end
    end

`ifdef FFT16_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_flag_q;

    assign to_hit = (state_q == ST_WAIT) && !i_bf_done &&
                    (to_cnt_q == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;
            if (to_hit) to_flag_q <= 1'b1;
        end
    end

    assign o_timeout = to_flag_q;
`else
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft16_scheduler.sv
// Scoreboard bench for fft16_scheduler: randomized butterfly latencies against
// a loop-based DIT reference of the butterfly order, addresses and pass timing.
module tb_fft16_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_bf_done;
    logic       o_busy, o_bf_start, o_rd_bank, o_wr_en, o_FFT_cycle_done, o_timeout;
    logic [3:0] o_addr_a, o_addr_b;
    logic [2:0] o_tw_idx, o_bf_idx;
    logic [1:0] o_stage;

    fft16_scheduler dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_bf_done        (i_bf_done),
        .o_busy           (o_busy),
        .o_bf_start       (o_bf_start),
        .o_addr_a         (o_addr_a),
        .o_addr_b         (o_addr_b),
        .o_tw_idx         (o_tw_idx),
        .o_stage          (o_stage),
        .o_bf_idx         (o_bf_idx),
        .o_rd_bank        (o_rd_bank),
        .o_wr_en          (o_wr_en),
        .o_FFT_cycle_done (o_FFT_cycle_done),
        .o_timeout        (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int stage;
        int bf;
        int a;
        int b;
        int tw;
    } iss_t;

    iss_t iss_q[$];
    int   wra_q[$];
    int   wrb_q[$];
    int   done_q[$];
    int   dto_q[$];
    int   wcnt_q[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lat[32];
    bit   spur[32];
    int   idx = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    bit   idle_chk = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: classic in-place DIT loop nest; stall = butterfly that never completes (32 = none)
    task automatic plan_pass(input int stall, input int x0);
        int   n = 0;
        int   tot = 0;
        bit   stopped = 0;
        iss_t e;
        for (int s = 0; s < 4; s++) begin
            for (int st = 0; st < 16; st += (2 << s)) begin
                for (int j = 0; j < (1 << s); j++) begin
                    if (!stopped) begin
                        e.stage = s;
                        e.bf    = n % 8;
                        e.a     = st + j;
                        e.b     = st + j + (1 << s);
                        e.tw    = j * (8 >> s);
                        iss_q.push_back(e);
                        if (n == stall) begin
                            tot += 1 + 15;
                            stopped = 1;
                        end else begin
                            wra_q.push_back(e.a);
                            wrb_q.push_back(e.b);
                            tot += lat[n] + 2;
                            n++;
                        end
                    end
                end
            end
        end
        done_q.push_back(x0 + tot + 1);
        dto_q.push_back((stall < 32) ? 1 : 0);
        wcnt_q.push_back(n);
    endtask

    task automatic randomize_lat();
        for (int i = 0; i < 32; i++) begin
            lat[i]  = $urandom_range(1, 4);
            spur[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic start_pass(input int stall);
        plan_pass(stall, cyc);
        idx = 0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic mid_pulse();
        repeat ($urandom_range(3, 15)) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (done_cnt == d0) chk("wait_done_bound", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_bf_start"}, o_bf_start, 0);
        chk({tag, "_addr_a"}, o_addr_a, 0);
        chk({tag, "_addr_b"}, o_addr_b, 0);
        chk({tag, "_tw_idx"}, o_tw_idx, 0);
        chk({tag, "_stage"}, o_stage, 0);
        chk({tag, "_bf_idx"}, o_bf_idx, 0);
        chk({tag, "_rd_bank"}, o_rd_bank, 0);
        chk({tag, "_wr_en"}, o_wr_en, 0);
        chk({tag, "_done"}, o_FFT_cycle_done, 0);
        chk({tag, "_timeout"}, o_timeout, 0);
    endtask

    task automatic clear_sb();
        iss_q.delete();
        wra_q.delete();
        wrb_q.delete();
        done_q.delete();
        dto_q.delete();
        wcnt_q.delete();
        wr_cnt   = 0;
        idle_chk = 0;
    endtask

    // Datapath model: optional stray done in the ISSUE cycle, real done L cycles later
    initial begin
        i_bf_done = 1'b0;
        forever begin
            @(negedge i_clk);
            i_bf_done = 1'b0;
            if (i_rst === 1'b1 && o_bf_start === 1'b1) begin
                int L;
                bit sp;
                L  = (idx < 32) ? lat[idx] : 2;
                sp = (idx < 32) ? spur[idx] : 1'b0;
                idx++;
                i_bf_done = sp;
                for (int k = 1; k <= L; k++) begin
                    @(negedge i_clk);
                    i_bf_done = (k == L);
                end
            end
        end
    end

    // Monitor
    always @(negedge i_clk) begin : mon
        iss_t e;
        int   ea, eb, ed, et, ew;
        if (i_rst === 1'b1) begin
            if (idle_chk) begin
                chk("busy_after_done", o_busy, 0);
                idle_chk = 0;
            end
            if (o_bf_start) begin
                if (iss_q.size() == 0) chk("unexpected_bf_start", 1, 0);
                else begin
                    e = iss_q.pop_front();
                    chk("iss_stage", o_stage, e.stage);
                    chk("iss_bf_idx", o_bf_idx, e.bf);
                    chk("iss_addr_a", o_addr_a, e.a);
                    chk("iss_addr_b", o_addr_b, e.b);
                    chk("iss_tw_idx", o_tw_idx, e.tw);
                    chk("iss_rd_bank", o_rd_bank, e.stage % 2);
                    chk("iss_busy", o_busy, 1);
                    chk("iss_wr_en", o_wr_en, 0);
                    chk("iss_timeout", o_timeout, 0);
                end
            end
            if (o_wr_en) begin
                wr_cnt++;
                if (wra_q.size() == 0) chk("unexpected_wr_en", 1, 0);
                else begin
                    ea = wra_q.pop_front();
                    eb = wrb_q.pop_front();
                    chk("wr_addr_a", o_addr_a, ea);
                    chk("wr_addr_b", o_addr_b, eb);
                    chk("wr_busy", o_busy, 1);
                end
            end
            if (o_FFT_cycle_done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    ed = done_q.pop_front();
                    et = dto_q.pop_front();
                    ew = wcnt_q.pop_front();
                    chk("done_cycle", cyc, ed);
                    chk("done_timeout", o_timeout, et);
                    chk("done_wr_count", wr_cnt, ew);
                    chk("done_busy", o_busy, 1);
                end
                wr_cnt   = 0;
                idle_chk = 1;
                done_cnt++;
            end
        end
    end

    initial begin
        int n;
        i_rst   = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            lat[i]  = 2;
            spur[i] = 1'b0;
        end
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b1;
        @(negedge i_clk);

        // Pass 1: fixed latency 2, done expected in cycle 129
        start_pass(32);
        mid_pulse();
        wait_done();

        // Pass 2: random latencies, aborted by reset during a stage-2 WAIT
        randomize_lat();
        start_pass(32);
        n = 0;
        while (!(o_stage == 2'd2 && o_busy && !o_bf_start && !o_wr_en && !o_FFT_cycle_done) && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 2000) chk("reach_stage2_wait", 0, 1);
        i_rst = 1'b0;
        #1;
        check_all_zero("abort");
        clear_sb();
        repeat (8) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);

        // Pass 3: stray done coincident with the first bf_start, real done 3 cycles later
        randomize_lat();
        lat[0]  = 3;
        spur[0] = 1'b1;
        start_pass(32);
        mid_pulse();
        wait_done();

`ifdef FFT16_TIMEOUT_EN
        randomize_lat();
        n = $urandom_range(0, 31);
        lat[n] = 0;
        start_pass(n);
        wait_done();
        chk("timeout_sticky", o_timeout, 1);
        i_rst = 1'b0;
        #1;
        check_all_zero("to_reset");
        clear_sb();
        repeat (8) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
`endif

        // Pass 4 chained into pass 5 by holding i_start through DONE
        randomize_lat();
        start_pass(32);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_FFT_cycle_done !== 1'b1 && n < 2000);
        if (n >= 2000) chk("chain_done_bound", 0, 1);
        randomize_lat();
        plan_pass(32, cyc + 1);
        idx = 0;
        i_start = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();

        @(negedge i_clk);
        chk("sb_iss_empty", iss_q.size(), 0);
        chk("sb_wr_empty", wra_q.size(), 0);
        chk("sb_done_empty", done_q.size(), 0);
        chk("final_idle_busy", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fft16_scheduler.md
Name: fft16_scheduler

Overview:
- Sequences the single shared radix-2 butterfly through a 16-point in-place DIT FFT: 4 stages × 8 butterflies.
- Each butterfly step generates:
  - the two operand addresses,
  - the twiddle index,
  - the butterfly start pulse,
  - the ping-pong buffer write strobe.
- Sits between the FFT16 top-level sample buffers and the butterfly/multiplier datapath. Replaces hard-wired mux switching with an explicit FSM, and reports completion through a cycle-done pulse.

Parameters:
- POINTS, 16, FFT length; must equal 2**STAGES.
- STAGES, 4, number of radix-2 stages.
- TO_CYCLES, 15, watchdog limit in cycles for i_bf_done; used only with FFT16_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  request a full FFT pass; sampled only in IDLE.
- i_bf_done  in  1  butterfly result valid pulse from datapath.
- o_busy  out  1  high from the first ISSUE through DONE.
- o_bf_start  out  1  one-cycle pulse launching the butterfly.
- o_addr_a  out  STAGES  upper-leg operand address.
- o_addr_b  out  STAGES  lower-leg operand address.
- o_tw_idx  out  STAGES-1  twiddle ROM index k of W16^k.
- o_stage  out  2  current stage, 0..STAGES-1.
- o_bf_idx  out  STAGES-1  butterfly index within stage, 0..7.
- o_rd_bank  out  1  buffer bank read this stage.
- o_wr_en  out  1  write strobe for both results into ~o_rd_bank at o_addr_a/o_addr_b.
- o_FFT_cycle_done  out  1  one-cycle pulse at pass completion.
- o_timeout  out  1  sticky watchdog flag; constant 0 without FFT16_TIMEOUT_EN.

Behaviour:
- Reset (i_rst=0, async): state IDLE; all outputs 0; counters stage=0, bf_idx=0.
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
  - IDLE: i_start=1 -> ISSUE.
  - ISSUE: exactly 1 cycle; o_bf_start=1; -> WAIT.
  - WAIT: stays in WAIT until i_bf_done=1; then -> WRITE.
  - WRITE: exactly 1 cycle; o_wr_en=1.
    - Increments bf_idx.
    - On wrap from 7 to 0, increments stage.
    - Goes to DONE if stage=3 and bf_idx=7; otherwise goes to ISSUE.
  - DONE: 1 cycle; o_FFT_cycle_done=1; stage and bf_idx cleared; -> IDLE.
- Address arithmetic for stage s and butterfly b:
  - half = 1<<s
  - pos = b & (half-1)
  - grp = b >> s
  - o_addr_a = grp*2*half + pos
  - o_addr_b = o_addr_a + half
  - o_tw_idx = pos << (STAGES-1-s)
- All arithmetic is modulo 2**STAGES and unsigned.
- Addresses and twiddle index are registered. They are stable from ISSUE through WRITE and change only on the WRITE->ISSUE edge.
- o_rd_bank = stage[0]. The final spectrum is in bank STAGES[0] (bank 0 for STAGES=4). Stage 0 reads the bit-reversed input loaded by the top level.
- i_bf_done is ignored outside WAIT, including when it coincides with o_bf_start. The datapath latency L is at least 1.
- i_start while o_busy is ignored; there is no queueing. i_start held high in DONE starts a new pass after returning to IDLE, i.e. the next pass begins 1 cycle later.
- Latency: the cycle after the edge that samples i_start is cycle 1 (ISSUE). o_FFT_cycle_done is high in cycle 32*(L+2)+1.
- Asynchronous reset mid-pass aborts immediately. No write strobe is issued; outputs return to reset values.

Optional Feature:
- Macro: FFT16_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TO_CYCLES without i_bf_done, o_timeout sets (sticky until reset) and the FSM goes to DONE.
  - o_FFT_cycle_done still pulses; no o_wr_en occurs for the stalled butterfly.
- Undefined: no counter; WAIT has no exit other than i_bf_done; o_timeout tied to 0.

Decomposition:
- Package fft16_pkg holds:
  - localparams POINTS and STAGES,
  - state encoding typedef for IDLE/ISSUE/WAIT/WRITE/DONE,
  - address width STAGES and twiddle width STAGES-1.
- Sub-module fft16_addr_gen is natural: combinational (stage, bf_idx) -> (addr_a, addr_b, tw_idx). The scheduler registers its outputs.

Test Plan:
- Reset, then i_start=1 with L=2 -> cycle 1: o_bf_start=1, o_addr_a=0, o_addr_b=1, o_tw_idx=0, o_rd_bank=0; o_busy=1.
- Stage 1, butterfly 1 -> o_addr_a=1, o_addr_b=3, o_tw_idx=4, o_rd_bank=1.
- Stage 2, butterfly 5 -> o_addr_a=9, o_addr_b=13, o_tw_idx=2. Stage 3, butterfly 7 -> o_addr_a=7, o_addr_b=15, o_tw_idx=7.
- Full pass with L=2 -> exactly 32 o_wr_en pulses; o_FFT_cycle_done in cycle 129; o_busy drops in cycle 130. i_start pulsed mid-pass has no effect.
- i_bf_done asserted together with o_bf_start, then again 3 cycles later -> first pulse ignored; WRITE follows the second pulse.
- i_rst driven low during WAIT of stage 2 -> outputs 0 asynchronously. Next i_start restarts at stage 0, butterfly 0. With FFT16_TIMEOUT_EN and i_bf_done withheld -> o_timeout=1 after 15 WAIT cycles, then o_FFT_cycle_done pulse.
